// File: rtl/cameralink_grab.sv
// cameralink_grab: CameraLink capture stage. Arms on command, aligns to a
// whole frame, pushes tagged pixels {sol, sof, rgb} into a small FIFO and
// reports line/width counts, frame completion and overflow.
// Optional checksum: define CAMERALINK_GRAB_CHECKSUM_EN to enable frame_sum.
module cameralink_grab #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned CNT_W   = 12
) (
  input  logic             CLOCK,
  input  logic             RESET_n,
  input  logic             VCE,
  input  logic             LVV,
  input  logic             FVV,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic             cam_enable,
  output logic             cam_request,
  input  logic             enable,
  input  logic             arm,
  output logic             busy,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [23:0]      pix_data,
  output logic             pix_sof,
  output logic             pix_sol,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] line_width,
  output logic             overflow,
  output logic [15:0]      frame_sum
);

  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam int unsigned ENTRY_W = 26;
  localparam int unsigned CW      = FIFO_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_ARMED   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               cam_enable_q, cam_enable_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   line_count_q, line_count_d;
  logic [CNT_W-1:0]   line_width_q, line_width_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               overflow_q, overflow_d;
  logic               lvv_q, lvv_d;
  logic               sof_pend_q, sof_pend_d;
  logic               sol_pend_q, sol_pend_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               wr_en_c;
  logic               rd_en_c;
  logic               full_c;
  logic               cap_cyc_c;
  logic               pix_in_c;
  logic               lvv_rise_c;
  logic               lvv_fall_c;
  logic               sol_now_c;
  logic [ENTRY_W-1:0] wr_entry_c;
  logic [ENTRY_W-1:0] head_c;

`ifdef CAMERALINK_GRAB_CHECKSUM_EN
  logic [15:0]        sum_q, sum_d;
  logic [15:0]        frame_sum_q, frame_sum_d;
`endif

  // Next-state, counters, FIFO control and checksum
  always_comb begin
    state_d      = state_q;
    cam_enable_d = enable;
    frame_done_d = 1'b0;
    line_count_d = line_count_q;
    line_width_d = line_width_q;
    pix_cnt_d    = pix_cnt_q;
    overflow_d   = overflow_q;
    lvv_d        = LVV;
    sof_pend_d   = sof_pend_q;
    sol_pend_d   = sol_pend_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wr_en_c      = 1'b0;
    wr_entry_c   = '0;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
    sum_d        = sum_q;
    frame_sum_d  = frame_sum_q;
`endif

    lvv_rise_c = LVV & ~lvv_q;
    lvv_fall_c = ~LVV & lvv_q;
    // The ARMED cycle that sees FVV rise is handled as the first capture cycle.
    cap_cyc_c  = (state_q == ST_CAPTURE) | ((state_q == ST_ARMED) & FVV);
    pix_in_c   = cap_cyc_c & FVV & LVV & VCE;
    full_c     = (count_q == CW'(DEPTH));
    rd_en_c    = (count_q != '0) & pix_ready;
    sol_now_c  = sol_pend_q | (cap_cyc_c & FVV & lvv_rise_c);

    // Line and per-line pixel counters, both saturating
    if (cap_cyc_c & FVV) begin
      if (lvv_rise_c) begin
        if (line_count_q != {CNT_W{1'b1}}) line_count_d = line_count_q + CNT_W'(1);
        pix_cnt_d = VCE ? CNT_W'(1) : '0;
      end else if (LVV & VCE & (pix_cnt_q != {CNT_W{1'b1}})) begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
      if (lvv_fall_c) line_width_d = pix_cnt_q;
    end

    // Pixel tagging and FIFO write; a full FIFO drops the pixel
    sol_pend_d = sol_now_c;
    if (pix_in_c) begin
      sol_pend_d = 1'b0;
      if (!full_c) begin
        wr_en_c    = 1'b1;
        wr_entry_c = {sol_now_c, sof_pend_q, blue, green, red};
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(1);
        sof_pend_d = 1'b0;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
        sum_d      = sum_q + 16'(red) + 16'(green) + 16'(blue);
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (rd_en_c) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

    case ({wr_en_c, rd_en_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Frame FSM
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d      = ST_SYNC;
          overflow_d   = 1'b0;
          line_count_d = '0;
          line_width_d = '0;
          pix_cnt_d    = '0;
          sof_pend_d   = 1'b1;
          sol_pend_d   = 1'b0;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end
      ST_SYNC: begin
        if (!FVV) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (FVV) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!FVV) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
          frame_sum_d  = sum_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (!RESET_n) begin
      state_q      <= ST_IDLE;
      cam_enable_q <= 1'b0;
      frame_done_q <= 1'b0;
      line_count_q <= '0;
      line_width_q <= '0;
      pix_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      lvv_q        <= 1'b0;
      sof_pend_q   <= 1'b0;
      sol_pend_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
      sum_q        <= '0;
      frame_sum_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cam_enable_q <= cam_enable_d;
      frame_done_q <= frame_done_d;
      line_count_q <= line_count_d;
      line_width_q <= line_width_d;
      pix_cnt_q    <= pix_cnt_d;
      overflow_q   <= overflow_d;
      lvv_q        <= lvv_d;
      sof_pend_q   <= sof_pend_d;
      sol_pend_q   <= sol_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
      sum_q        <= sum_d;
      frame_sum_q  <= frame_sum_d;
`endif
    end
  end

  // FIFO storage; contents are qualified by count, so no reset needed
  always_ff @(posedge CLOCK) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= wr_entry_c;
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign pix_valid   = (count_q != '0);
  assign pix_data    = pix_valid ? head_c[23:0] : '0;
  assign pix_sof     = pix_valid & head_c[24];
  assign pix_sol     = pix_valid & head_c[25];
  assign busy        = (state_q != ST_IDLE);
  assign cam_request = (state_q == ST_ARMED);
  assign cam_enable  = cam_enable_q;
  assign frame_done  = frame_done_q;
  assign line_count  = line_count_q;
  assign line_width  = line_width_q;
  assign overflow    = overflow_q;
`ifdef CAMERALINK_GRAB_CHECKSUM_EN
  assign frame_sum   = frame_sum_q;
`else
  assign frame_sum   = 16'h0000;
`endif

endmodule

// File: doc/cameralink_grab.md
Name: cameralink_grab

Overview:
- Frame-grabber capture stage directly downstream of the CameraLink receiver wrapper.
- Consumes the receiver's CLOCK, VCE/LVV/FVV strobes and 24-bit RGB; drives back cam_enable/cam_request.
- Arms on command, aligns to a whole frame, and pushes tagged pixels into an internal FIFO with a valid/ready output.
- Reports line/width counts, frame completion and overflow to the capture controller.

Parameters:
- FIFO_AW, 4: FIFO address bits; depth = 2**FIFO_AW entries of 26 bits {sol, sof, rgb}.
- CNT_W, 12: width of line and pixel counters; counters saturate at 2**CNT_W-1.

Ports:
- CLOCK  in  1  capture clock, the clock produced by the receiver wrapper.
- RESET_n  in  1  synchronous active-low reset.
- VCE, LVV, FVV  in  1 each  pixel-valid, line-valid and frame-valid from the receiver.
- red, green, blue  in  8 each  pixel components.
- cam_enable  out  1  camera enable, registered copy of enable.
- cam_request  out  1  frame request to the camera.
- enable  in  1  controller camera enable.
- arm  in  1  single-cycle request to capture one frame.
- busy  out  1  high in any state other than IDLE.
- pix_valid  out  1  FIFO not empty.
- pix_ready  in  1  consumer accepts the head entry when pix_valid=1.
- pix_data  out  24  {blue, green, red} of the head entry.
- pix_sof  out  1  head entry is the first pixel of the frame.
- pix_sol  out  1  head entry is the first pixel of a line.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- line_count  out  CNT_W  lines in the current or last frame.
- line_width  out  CNT_W  pixel count of the last completed line.
- overflow  out  1  sticky flag; a pixel was dropped because the FIFO was full.
- frame_sum  out  16  frame checksum (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, all counters 0. Reset mid-capture discards the FIFO contents and the partial frame.
- cam_enable <= enable every cycle, so it lags enable by 1 cycle.
- FSM states: IDLE, SYNC, ARMED, CAPTURE.
  - IDLE: on arm=1 -> SYNC; overflow, line_count, line_width and the checksum clear on the same edge.
  - SYNC: wait for FVV=0 so a partial frame is never captured, then -> ARMED.
  - ARMED: cam_request=1. When FVV=1 -> CAPTURE and cam_request drops on the same edge. That FVV=1 cycle is processed as the first CAPTURE cycle.
  - CAPTURE: when FVV=0 -> IDLE, frame_done=1 for exactly that one cycle.
  - arm is ignored in every state except IDLE.
- Pixel write: occurs on a cycle in CAPTURE, or on the ARMED->CAPTURE edge, with FVV&LVV&VCE=1.
  - sof=1 on the first written pixel of the frame.
  - sol=1 on the first pixel after an LVV rising edge.
- Line counting: line_count increments on each LVV 0->1 while FVV=1 in CAPTURE.
  - The per-line pixel counter resets at LVV rise and increments per valid pixel.
  - line_width latches the pixel counter at LVV 1->0.
  - Both saturate; no wrap.
- FIFO:
  - Write when not full. When full, the pixel is dropped and overflow is set, even if a read happens in the same cycle. Capture continues.
  - Read when pix_valid&pix_ready.
  - Simultaneous read and write on a non-full, non-empty FIFO leaves the count unchanged.
  - pix_* reflect the head entry combinationally from the FIFO RAM; latency from write to pix_valid is 1 cycle.
- Pointers wrap modulo depth; a separate count of FIFO_AW+1 bits distinguishes full from empty.
- FVV dropping mid-line ends the frame normally; line_width is not updated for that truncated line.

Optional Feature:
- Macro CAMERALINK_GRAB_CHECKSUM_EN.
- Defined: a 16-bit accumulator adds red+green+blue of every pixel written (dropped pixels excluded), modulo 2^16. It clears on arm and latches into frame_sum on the frame_done cycle.
- Undefined: no accumulator logic; frame_sum tied to 0.

Test Plan:
- Reset, then arm while FVV=1 mid-frame -> FSM holds SYNC until FVV=0. cam_request rises the next cycle and falls at FVV rise. The partial frame writes nothing.
- 3 lines x 4 pixels, pix_ready=1 -> 12 entries read out; sof only on entry 0; sol on entries 0,4,8. line_count=3, line_width=4, one frame_done pulse, overflow=0.
- FIFO_AW=4, pix_ready=0, 20-pixel line -> 16 entries held; overflow=1. After arm clears it: read 16 entries in order, pixels 16-19 absent.
- VCE toggling 0/1 during LVV for 10 cycles -> exactly 5 pixels written; line_width=5.
- With CAMERALINK_GRAB_CHECKSUM_EN, 2 pixels (r,g,b)=(0xFF,0xFF,0xFF) and (1,2,3) -> frame_sum=0x0303. Without the macro -> frame_sum=0.
- RESET_n low for 1 cycle during CAPTURE with 5 entries queued -> pix_valid=0, busy=0, line_count=0 next cycle. The later FVV fall produces no frame_done.
